// File: rtl/servant_dbg_bridge.sv
// rtl/servant_dbg_bridge.sv - UART byte-stream to Wishbone debug initiator bridge
module servant_dbg_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_ERR   = 8'h45;
  localparam logic [7:0]  RSP_UNK   = 8'h3F;
  // Last value of the timeout counter before the cycle is abandoned
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic [15:0] r_tmo;
  logic [31:0] r_rdata;
  logic [2:0]  r_remain;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_cyc;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic        w_rx_fire;
  logic        w_tx_fire;

  // Byte intake is open only while a command is being assembled
  assign o_rx_ready = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign o_busy     = (r_state != S_IDLE);
  assign w_rx_fire  = i_rx_valid & o_rx_ready;
  assign w_tx_fire  = r_tx_valid & i_tx_ready;

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_wb_adr   = r_adr;
  assign o_wb_dat   = r_dat;
  assign o_wb_sel   = r_sel;
  assign o_wb_we    = r_we;
  assign o_wb_cyc   = r_cyc;

  // Command parser, bus initiator and response serializer in one FSM
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 2'd0;
      r_tmo      <= 16'd0;
      r_rdata    <= 32'd0;
      r_remain   <= 3'd0;
      r_adr      <= 32'd0;
      r_dat      <= 32'd0;
      r_sel      <= 4'h0;
      r_we       <= 1'b0;
      r_cyc      <= 1'b0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_byte_cnt <= 2'd0;
            if (i_rx_data == CMD_WRITE) begin
              r_we    <= 1'b1;
              r_state <= S_ADDR;
            end else if (i_rx_data == CMD_READ) begin
              r_we    <= 1'b0;
              r_state <= S_ADDR;
            end else begin
              r_tx_data  <= RSP_UNK;
              r_tx_valid <= 1'b1;
              r_remain   <= 3'd0;
              r_state    <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (w_rx_fire) begin
            r_adr[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_we) begin
                r_state <= S_DATA;
              end else begin
                r_cyc   <= 1'b1;
                r_sel   <= 4'hF;
                r_tmo   <= 16'd0;
                r_state <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (w_rx_fire) begin
            r_dat[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_cyc   <= 1'b1;
              r_sel   <= 4'hF;
              r_tmo   <= 16'd0;
              r_state <= S_BUS;
            end
          end
        end

        S_BUS: begin
          // An ack is checked before the timeout so a last-cycle ack still succeeds
          if (i_wb_ack) begin
            r_cyc      <= 1'b0;
            r_sel      <= 4'h0;
            if (!r_we) begin
              r_rdata <= i_wb_rdt;
            end
            r_tx_data  <= RSP_OK;
            r_tx_valid <= 1'b1;
            r_remain   <= r_we ? 3'd0 : 3'd4;
            r_state    <= S_RESP;
          end else if (r_tmo == TMO_LAST) begin
            r_cyc      <= 1'b0;
            r_sel      <= 4'h0;
            r_tx_data  <= RSP_ERR;
            r_tx_valid <= 1'b1;
            r_remain   <= 3'd0;
            r_state    <= S_RESP;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end

        S_RESP: begin
          // Read data is shifted out LSB first after the status byte
          if (w_tx_fire) begin
            if (r_remain == 3'd0) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data <= r_rdata[7:0];
              r_rdata   <= {8'd0, r_rdata[31:8]};
              r_remain  <= r_remain - 3'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servant_dbg_bridge.sv
// tb/tb_servant_dbg_bridge.sv - randomized self-checking bench for servant_dbg_bridge
module tb_servant_dbg_bridge;

  localparam int TIMEOUT = 255;

  logic        wb_clk;
  logic        wb_rst_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_busy;

  int tests_run;
  int tests_failed;

  // Reference state: address/data registers persist across commands
  logic [31:0] m_adr;
  logic [31:0] m_dat;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  servant_dbg_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (i_wb_ack),
    .o_busy     (o_busy)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_tx_ready = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_rdt   = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"},   {63'd0, o_wb_cyc},   64'd0);
    check({tag, "_we"},    {63'd0, o_wb_we},    64'd0);
    check({tag, "_sel"},   {60'd0, o_wb_sel},   64'd0);
    check({tag, "_adr"},   {32'd0, o_wb_adr},   64'd0);
    check({tag, "_dat"},   {32'd0, o_wb_dat},   64'd0);
    check({tag, "_txv"},   {63'd0, o_tx_valid}, 64'd0);
    check({tag, "_txd"},   {56'd0, o_tx_data},  64'd0);
    check({tag, "_busy"},  {63'd0, o_busy},     64'd0);
    check({tag, "_rxrdy"}, {63'd0, o_rx_ready}, 64'd1);
  endtask

  // ack_at: cycle of o_wb_cyc (1-based) in which the responder acks, 0 = never.
  // bp_pct: percentage of cycles with i_tx_ready low. abort_cyc: reset after that many cyc cycles.
  task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] adr,
                         input logic [31:0] dat, input int ack_at, input logic [31:0] rdt,
                         input int bp_pct, input int abort_cyc);
    bit          is_w, is_r, ok, done, post_chk, aborted, prev_pending;
    int          exp_cyc, cyc_cnt, bus_bad, stab_bad, rxr_bad;
    logic [7:0]  prev_data;
    logic [63:0] exp_pk, got_pk;

    is_w = (cmd == 8'h57);
    is_r = (cmd == 8'h52);
    ok   = (ack_at > 0) && (ack_at <= TIMEOUT);

    rx_q.delete();
    exp_q.delete();
    got_q.delete();
    rx_q.push_back(cmd);
    if (is_w || is_r) begin
      for (int i = 0; i < 4; i++) rx_q.push_back(adr[8*i +: 8]);
      m_adr = adr;
    end
    if (is_w) begin
      for (int i = 0; i < 4; i++) rx_q.push_back(dat[8*i +: 8]);
      m_dat = dat;
    end

    if (!(is_w || is_r)) begin
      exp_q.push_back(8'h3F);
      exp_cyc = 0;
    end else begin
      exp_cyc = ok ? ack_at : TIMEOUT;
      exp_q.push_back(ok ? 8'h4B : 8'h45);
      if (is_r && ok) for (int i = 0; i < 4; i++) exp_q.push_back(rdt[8*i +: 8]);
    end

    cyc_cnt = 0; bus_bad = 0; stab_bad = 0; rxr_bad = 0;
    done = 0; post_chk = 0; aborted = 0; prev_pending = 0; prev_data = 8'h00;

    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge wb_clk);
      if (post_chk) begin
        check({tag, "_end_txv"},   {63'd0, o_tx_valid}, 64'd0);
        check({tag, "_end_busy"},  {63'd0, o_busy},     64'd0);
        check({tag, "_end_rxrdy"}, {63'd0, o_rx_ready}, 64'd1);
        done = 1;
      end else begin
        if (o_wb_cyc) begin
          cyc_cnt++;
          if (o_wb_adr !== m_adr || o_wb_dat !== m_dat || o_wb_we !== is_w || o_wb_sel !== 4'hF)
            bus_bad++;
        end
        if ((o_tx_valid || o_wb_cyc) && o_rx_ready) rxr_bad++;
        if (prev_pending && (!o_tx_valid || o_tx_data !== prev_data)) stab_bad++;

        i_wb_ack = o_wb_cyc && (ack_at > 0) && (cyc_cnt == ack_at);
        i_wb_rdt = i_wb_ack ? rdt : $urandom;
        i_tx_ready = ($urandom_range(99) >= bp_pct);
        if (rx_q.size() > 0) begin
          i_rx_valid = ($urandom_range(3) != 0);
          i_rx_data  = rx_q[0];
        end else begin
          i_rx_valid = 1'b0;
          i_rx_data  = 8'($urandom);
        end

        if (i_rx_valid && o_rx_ready) void'(rx_q.pop_front());
        if (o_tx_valid && i_tx_ready) begin
          got_q.push_back(o_tx_data);
          prev_pending = 0;
          if (got_q.size() >= exp_q.size()) post_chk = 1;
        end else begin
          prev_pending = o_tx_valid;
          prev_data    = o_tx_data;
        end

        if (abort_cyc > 0 && cyc_cnt == abort_cyc) begin
          #2 wb_rst_n = 1'b0;
          #1;
          check_reset_outputs({tag, "_abort"});
          idle_inputs();
          repeat (3) @(negedge wb_clk);
          check({tag, "_held_cyc"}, {63'd0, o_wb_cyc}, 64'd0);
          wb_rst_n = 1'b1;
          m_adr = 32'd0;
          m_dat = 32'd0;
          aborted = 1;
          done = 1;
        end
      end
    end
    idle_inputs();

    check({tag, "_done"}, {63'd0, done}, 64'd1);
    if (!aborted) begin
      exp_pk = 64'd0;
      got_pk = 64'd0;
      foreach (exp_q[i]) exp_pk = (exp_pk << 8) | 64'(exp_q[i]);
      foreach (got_q[i]) got_pk = (got_pk << 8) | 64'(got_q[i]);
      check({tag, "_cyc_len"}, 64'(cyc_cnt), 64'(exp_cyc));
      check({tag, "_ntx"},     64'(got_q.size()), 64'(exp_q.size()));
      check({tag, "_tx"},      got_pk, exp_pk);
      check({tag, "_bus"},     64'(bus_bad), 64'd0);
      check({tag, "_stable"},  64'(stab_bad), 64'd0);
      check({tag, "_rxrdy"},   64'(rxr_bad), 64'd0);
    end
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [31:0] adr, dat, rdt;
    int          ack_at, sel;

    tests_run    = 0;
    tests_failed = 0;
    m_adr = 32'd0;
    m_dat = 32'd0;
    idle_inputs();
    wb_rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    check_reset_outputs("post_reset");

    run_cmd("write",       8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 3,   32'h0,          0,  0);
    run_cmd("read",        8'h52, 32'h0000_1000, 32'h0,         1,   32'h1234_5678,  0,  0);
    run_cmd("unknown",     8'h00, 32'h0,         32'h0,         1,   32'h0,          0,  0);
    run_cmd("tmo_write",   8'h57, 32'hA5A5_0004, 32'h0102_0304, 0,   32'h0,          0,  0);
    run_cmd("tmo_lastack", 8'h52, 32'h0000_0020, 32'h0,         255, 32'hCAFE_F00D,  0,  0);
    run_cmd("tmo_read",    8'h52, 32'h0000_0024, 32'h0,         256, 32'h1111_2222,  0,  0);
    run_cmd("backpress",   8'h52, 32'h0000_0030, 32'h0,         2,   32'h8765_4321,  75, 0);
    run_cmd("abort_bus",   8'h57, 32'h0000_0044, 32'h5555_AAAA, 0,   32'h0,          0,  5);
    run_cmd("after_abort", 8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 3,   32'h0,          0,  0);
    run_cmd("read_back",   8'h52, 32'h0000_0010, 32'h0,         4,   32'h0BAD_CAFE,  30, 0);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(9);
      cmd = (sel < 4) ? 8'h57 : (sel < 8) ? 8'h52 : 8'($urandom);
      adr = $urandom;
      dat = $urandom;
      rdt = $urandom;
      ack_at = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 8);
      run_cmd($sformatf("rand%0d", n), cmd, adr, dat, ack_at, rdt, $urandom_range(60), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/servant_dbg_bridge.md
SERVANT_DBG_BRIDGE -- requirements
Module: servant_dbg_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 255, bus cycles without ack before abort; legal range 1..65535.
REQ-002 wb_clk  in  1  single clock; all logic on rising edge.
REQ-003 wb_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_rx_data  in  8  command byte stream from UART receiver.
REQ-005 i_rx_valid  in  1  i_rx_data valid; byte accepted when i_rx_valid & o_rx_ready.
REQ-006 o_rx_ready  out  1  bridge can accept a byte.
REQ-007 o_tx_data  out  8  response byte.
REQ-008 o_tx_valid  out  1  o_tx_data valid; byte sent when o_tx_valid & i_tx_ready.
REQ-009 i_tx_ready  in  1  downstream transmitter accepts byte.
REQ-010 o_wb_adr  out  32  Wishbone initiator address.
REQ-011 o_wb_dat  out  32  write data.
REQ-012 o_wb_sel  out  4  byte enables, always 4'hF during a cycle.
REQ-013 o_wb_we  out  1  write enable.
REQ-014 o_wb_cyc  out  1  cycle request (no separate stb).
REQ-015 i_wb_rdt  in  32  read data, valid with ack.
REQ-016 i_wb_ack  in  1  responder ack; sampled only while o_wb_cyc=1.
REQ-017 o_busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, ADDR, DATA, BUS, RESP.
REQ-019 o_rx_ready SHALL be 1 in IDLE, ADDR, DATA and 0 in BUS, RESP.
REQ-020 IDLE, byte 0x57 ('W') -> ADDR with we=1; byte 0x52 ('R') -> ADDR with we=0; any other byte -> RESP queuing single byte 0x3F ('?'), no bus cycle.
REQ-021 ADDR: accept 4 bytes, LSB first, into o_wb_adr; after 4th byte -> DATA if write, else BUS.
REQ-022 DATA: accept 4 bytes, LSB first, into o_wb_dat; after 4th byte -> BUS.
REQ-023 Byte counter 2 bits, cleared on entry to ADDR and DATA; wraps 3->0 on state exit.
REQ-024 BUS: o_wb_cyc=1 from the first cycle in BUS; adr/dat/we/sel held stable throughout.
REQ-025 Ack in BUS: o_wb_cyc=0 next cycle; read captures i_wb_rdt that same edge; -> RESP with status 0x4B ('K').
REQ-026 Timeout counter cleared on entry to BUS, +1 each BUS cycle without ack; o_wb_cyc high exactly TIMEOUT cycles, then -> RESP with status 0x45 ('E').
REQ-027 Ack in the final timeout cycle SHALL win: status 'K', data captured.
REQ-028 RESP write or any 'E': send status byte only; read with 'K': send status then 4 read-data bytes LSB first; unknown cmd: send 0x3F only.
REQ-029 o_tx_data SHALL stay stable while o_tx_valid=1 and i_tx_ready=0; next byte presented the cycle after handshake; back-to-back handshakes every cycle supported.
REQ-030 After last response byte handshake -> IDLE; o_tx_valid=0 that next cycle.
REQ-031 Bytes presented while o_rx_ready=0 SHALL NOT be consumed (source holds them).
REQ-032 o_wb_dat, o_wb_adr not cleared between commands; only o_wb_cyc qualifies them.

Reset
REQ-033 wb_rst_n=0 SHALL immediately force: state IDLE, o_wb_cyc=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_tx_valid=0, o_tx_data=0, o_busy=0, counters 0; o_rx_ready=1.
REQ-034 Reset mid-BUS or mid-RESP SHALL abort with no further bus activity or tx bytes; first command after release processed normally.

Verification
REQ-035 Write: 57,10,00,00,00,EF,BE,AD,DE; ack 2 cycles after cyc -> adr=0x00000010, dat=0xDEADBEEF, we=1, sel=F, cyc high 3 cycles; tx 4B.
REQ-036 Read: 52,00,10,00,00; ack first cycle with rdt=0x12345678 -> cyc high 1 cycle, we=0; tx 4B,78,56,34,12.
REQ-037 Timeout, TIMEOUT=255, never ack -> cyc high exactly 255 cycles; tx 45; ack in cycle 255 -> tx 4B.
REQ-038 Unknown cmd 0x00 -> tx 3F, o_wb_cyc never asserted, back to IDLE, o_rx_ready=1.
REQ-039 Backpressure: i_tx_ready low 10 cycles during read response -> o_tx_data stable, all 5 bytes delivered in order, o_rx_ready=0 throughout.
REQ-040 wb_rst_n low mid-BUS -> o_wb_cyc=0 without waiting for clock edge; after release, write command per REQ-035 completes correctly.
